// File: rtl/duty_ramp_pkg.sv
// Shared definitions for the servo gate duty ramp: the state encoding,
// datapath widths and the default duty/step constants.
package duty_ramp_pkg;

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } state_e;

    // Width of the duty count handed to the PWM comparator.
    localparam int unsigned ANGLE_W = 19;
    // One extra bit so angle + STEP cannot wrap before it is clamped.
    localparam int unsigned CALC_W  = ANGLE_W + 1;

    // Defaults for a 25 MHz clock: 1.0 ms closed, 2.0 ms open.
    localparam int unsigned DUTY_CLOSED_DEF = 25000;
    localparam int unsigned DUTY_OPEN_DEF   = 50000;
    localparam int unsigned STEP_DEF        = 250;

endpackage

// File: rtl/duty_ramp.sv
// Servo gate duty ramp. On every PWM frame strobe the duty count moves one
// STEP towards the commanded end position, saturating exactly at the end
// value. An obstruction always drives the gate towards open.
module duty_ramp
    import duty_ramp_pkg::*;
#(
    parameter int unsigned DUTY_CLOSED = DUTY_CLOSED_DEF,
    parameter int unsigned DUTY_OPEN   = DUTY_OPEN_DEF,
    parameter int unsigned STEP        = STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame,
    input  logic               mover,
    input  logic               obstruct,
    output logic [ANGLE_W-1:0] angle_out,
    output logic               busy,
    output logic               at_open,
    output logic               at_closed,
    output logic               done
);

    localparam logic [CALC_W-1:0]  OPEN_C    = CALC_W'(DUTY_OPEN);
    localparam logic [CALC_W-1:0]  STEP_C    = CALC_W'(STEP);
    // At or below this angle a down step lands on (or past) DUTY_CLOSED.
    localparam logic [CALC_W-1:0]  LOW_TRIP  = CALC_W'(DUTY_CLOSED + STEP);
    localparam logic [ANGLE_W-1:0] OPEN_A    = ANGLE_W'(DUTY_OPEN);
    localparam logic [ANGLE_W-1:0] CLOSED_A  = ANGLE_W'(DUTY_CLOSED);
    localparam logic [ANGLE_W-1:0] STEP_A    = ANGLE_W'(STEP);

    state_e             state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               busy_q, busy_d;
    logic               at_open_q, at_open_d;
    logic               at_closed_q, at_closed_d;
    logic               done_q, done_d;

    logic               want_open;
    logic [CALC_W-1:0]  angle_ext;
    logic [CALC_W-1:0]  sum_up;
    logic [ANGLE_W-1:0] diff_dn;

    // Saturating add/subtract datapath; the subtract result is only used
    // when the angle is safely above LOW_TRIP, so it never underflows.
    always_comb begin
        angle_ext = {1'b0, angle_q};
        sum_up    = angle_ext + STEP_C;
        diff_dn   = angle_q - STEP_A;
    end

    // Next state and next angle, evaluated only on frame strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        angle_d   = angle_q;
        done_d    = 1'b0;
        want_open = mover | obstruct;
        if (frame) begin
            if (want_open && (state_q != ST_OPEN)) begin
                if (sum_up >= OPEN_C) begin
                    state_d = ST_OPEN;
                    angle_d = OPEN_A;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_OPENING;
                    angle_d = sum_up[ANGLE_W-1:0];
                end
            end else if (!want_open && (state_q != ST_CLOSED)) begin
                if (angle_ext <= LOW_TRIP) begin
                    state_d = ST_CLOSED;
                    angle_d = CLOSED_A;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_CLOSING;
                    angle_d = diff_dn;
                end
            end
        end
    end

    // Status flags decoded from the next state so they line up with state_q.
    always_comb begin
        busy_d      = (state_d == ST_OPENING) || (state_d == ST_CLOSING);
        at_open_d   = (state_d == ST_OPEN);
        at_closed_d = (state_d == ST_CLOSED);
    end

    // State, angle and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples values from before the edge, independent of statement order.
        if (rst) begin
            state_q     <= ST_CLOSED;
            angle_q     <= CLOSED_A;
            busy_q      <= 1'b0;
            at_open_q   <= 1'b0;
            at_closed_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            angle_q     <= angle_d;
            busy_q      <= busy_d;
            at_open_q   <= at_open_d;
            at_closed_q <= at_closed_d;
            done_q      <= done_d;
        end
    end

    assign angle_out = angle_q;
    assign busy      = busy_q;
    assign at_open   = at_open_q;
    assign at_closed = at_closed_q;
    assign done      = done_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Scoreboard bench for duty_ramp: two instances (default STEP and STEP=300)
// share the stimulus; a behavioural model pushes the expected outputs for
// each cycle and they are popped and compared one edge later.
module tb_duty_ramp;

    localparam int S_CLOSED  = 0;
    localparam int S_OPENING = 1;
    localparam int S_OPEN    = 2;
    localparam int S_CLOSING = 3;

    localparam int D_CLOSED = 25000;
    localparam int D_OPEN   = 50000;

    typedef struct packed {
        logic [18:0] angle;
        logic        busy;
        logic        at_open;
        logic        at_closed;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, frame, mover, obstruct;
    logic [18:0] angle0, angle1;
    logic        busy0, busy1, at_open0, at_open1, at_closed0, at_closed1;
    logic        done0, done1;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   m_st[2]  = '{S_CLOSED, S_CLOSED};
    int   m_ang[2] = '{D_CLOSED, D_CLOSED};
    int   steps[2] = '{250, 300};

    int   done_cnt0;
    int   prev1   = D_CLOSED;
    bit   seen_open1 = 1'b0;
    int   s300_max = 0;
    int   s300_min = 1 << 20;

    duty_ramp u_dut0 (
        .clk(clk), .rst(rst), .frame(frame), .mover(mover), .obstruct(obstruct),
        .angle_out(angle0), .busy(busy0), .at_open(at_open0),
        .at_closed(at_closed0), .done(done0)
    );

    duty_ramp #(.STEP(300)) u_dut1 (
        .clk(clk), .rst(rst), .frame(frame), .mover(mover), .obstruct(obstruct),
        .angle_out(angle1), .busy(busy1), .at_open(at_open1),
        .at_closed(at_closed1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Behavioural model of one clock edge for instance idx.
    task automatic model_update(input int idx, input bit fr, input bit mv,
                                input bit ob, input bit rs, output exp_t e);
        int st  = m_st[idx];
        int ang = m_ang[idx];
        bit dn  = 1'b0;
        bit go_open = mv || ob;
        if (rs) begin
            st  = S_CLOSED;
            ang = D_CLOSED;
        end else if (fr) begin
            if (go_open && st != S_OPEN) begin
                ang = ang + steps[idx];
                st  = S_OPENING;
                if (ang >= D_OPEN) begin
                    ang = D_OPEN;
                    st  = S_OPEN;
                    dn  = 1'b1;
                end
            end else if (!go_open && st != S_CLOSED) begin
                ang = ang - steps[idx];
                st  = S_CLOSING;
                if (ang <= D_CLOSED) begin
                    ang = D_CLOSED;
                    st  = S_CLOSED;
                    dn  = 1'b1;
                end
            end
        end
        m_st[idx]   = st;
        m_ang[idx]  = ang;
        e.angle     = 19'(ang);
        e.busy      = (st == S_OPENING) || (st == S_CLOSING);
        e.at_open   = (st == S_OPEN);
        e.at_closed = (st == S_CLOSED);
        e.done      = dn;
    endtask

    // Pop one expected entry per instance and compare against the outputs.
    task automatic compare_outputs();
        exp_t e0, e1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check("dut0_outputs", 32'({angle0, busy0, at_open0, at_closed0, done0}), 32'(e0));
        check("dut1_outputs", 32'({angle1, busy1, at_open1, at_closed1, done1}), 32'(e1));
        if (done0) done_cnt0++;
        if (!seen_open1 && angle1 == 19'(D_OPEN)) begin
            seen_open1 = 1'b1;
            // Last full step before the clamp: the largest multiple of 300
            // strictly inside the 25000-count span, added to DUTY_CLOSED.
            check("s300_partial_from", 32'(prev1), 32'(D_CLOSED + ((D_OPEN - D_CLOSED - 1) / 300) * 300));
        end
        if (int'(angle1) > s300_max) s300_max = int'(angle1);
        if (int'(angle1) < s300_min) s300_min = int'(angle1);
        prev1 = int'(angle1);
    endtask

    task automatic cycle(input bit fr, input bit mv, input bit ob, input bit rs);
        exp_t e0, e1;
        frame    = fr;
        mover    = mv;
        obstruct = ob;
        rst      = rs;
        model_update(0, fr, mv, ob, rs, e0);
        model_update(1, fr, mv, ob, rs, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        int hold_angle;
        rst = 1'b1; frame = 1'b0; mover = 1'b0; obstruct = 1'b0;

        // Reset, with a frame present to show reset wins.
        cycle(0, 0, 0, 1);
        cycle(1, 1, 0, 1);
        check("reset_angle", 32'(angle0), 32'(D_CLOSED));
        check("reset_at_closed", 32'(at_closed0), 32'd1);

        // Open with a frame every 10 cycles.
        done_cnt0 = 0;
        for (int f = 0; f < 100; f++) begin
            cycle(1, 1, 0, 0);
            repeat (9) cycle(0, 1, 0, 0);
        end
        check("open_angle", 32'(angle0), 32'(D_OPEN));
        check("open_at_open", 32'(at_open0), 32'd1);
        check("open_done_count", 32'(done_cnt0), 32'd1);
        check("s300_open_angle", 32'(angle1), 32'(D_OPEN));
        check("s300_seen_open", 32'(seen_open1), 32'd1);

        // Close again.
        done_cnt0 = 0;
        for (int f = 0; f < 100; f++) begin
            cycle(1, 0, 0, 0);
            repeat (9) cycle(0, 0, 0, 0);
        end
        check("close_angle", 32'(angle0), 32'(D_CLOSED));
        check("close_at_closed", 32'(at_closed0), 32'd1);
        check("close_busy", 32'(busy0), 32'd0);
        check("close_done_count", 32'(done_cnt0), 32'd1);
        check("s300_max", 32'(s300_max), 32'(D_OPEN));
        check("s300_min", 32'(s300_min), 32'(D_CLOSED));

        // Back-to-back frames up to 40250, one frame down to 40000, then an
        // obstruction with mover low reopens.
        for (int f = 0; f < 61; f++) cycle(1, 1, 0, 0);
        check("b2b_angle", 32'(angle0), 32'd40250);
        cycle(1, 0, 0, 0);
        check("closing_angle", 32'(angle0), 32'd40000);
        check("closing_busy", 32'(busy0), 32'd1);
        cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 0);
        check("reopen_angle", 32'(angle0), 32'd40250);
        check("reopen_busy", 32'(busy0), 32'd1);
        cycle(1, 0, 1, 0);
        check("reopen_dir_angle", 32'(angle0), 32'd40500);

        // Reset mid-opening at 37500.
        cycle(0, 0, 0, 1);
        for (int f = 0; f < 50; f++) cycle(1, 1, 0, 0);
        check("mid_open_angle", 32'(angle0), 32'd37500);
        cycle(1, 1, 0, 1);
        check("midrst_angle", 32'(angle0), 32'(D_CLOSED));
        check("midrst_at_closed", 32'(at_closed0), 32'd1);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        cycle(0, 1, 0, 0);
        check("midrst_hold_angle", 32'(angle0), 32'(D_CLOSED));
        cycle(1, 1, 0, 0);
        check("first_move_after_rst", 32'(angle0), 32'd25250);

        // Mid-travel, then mover/obstruct wiggled with frame held low.
        for (int f = 0; f < 10; f++) cycle(1, 1, 0, 0);
        hold_angle = int'(angle0);
        for (int i = 0; i < 1000; i++) cycle(0, bit'(i & 1), bit'($urandom_range(0, 1)), 0);
        check("hold_angle", 32'(angle0), 32'(hold_angle));
        check("hold_busy", 32'(busy0), 32'd1);

        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
